// File: rtl/dma_bus_arbiter.sv
// Round-robin arbiter for the shared DMA/Wishbone master port. One requester owns the port per
// burst. Bursts are capped at MAX_BEATS acked beats, and one requester index gets priority.
module dma_bus_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BEATS = 16,
  parameter int HIPRI_IDX = 3
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_i,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             last,
  input  logic                           ack_i,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [$clog2(NUM_REQ)-1:0]     gnt_id,
  output logic                           busy,
  output logic                           preempt,
  output logic [$clog2(MAX_BEATS+1)-1:0] beat_cnt
);

  localparam int unsigned NR        = NUM_REQ;
  localparam int unsigned IDW       = $clog2(NUM_REQ);
  localparam int unsigned CW        = $clog2(MAX_BEATS + 1);
  localparam bit          HIPRI_EN  = (HIPRI_IDX >= 0) && (HIPRI_IDX < NUM_REQ);
  localparam int unsigned HIPRI_SEL = HIPRI_EN ? HIPRI_IDX : 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]     gnt_id_q, gnt_id_d;
  logic               busy_q, busy_d;
  logic               preempt_q, preempt_d;
  logic [CW-1:0]      beat_cnt_q, beat_cnt_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic               hipri_last_q, hipri_last_d;

  logic               win_valid;
  logic               win_hipri;
  logic [IDW-1:0]     win_idx;
  logic [NUM_REQ-1:0] rr_req;
  int unsigned        rr_idx;
  logic [IDW-1:0]     rr_idx_l;

  logic               cur_req, cur_last;
  logic               rel_a, rel_b, rel_c;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] i);
    int unsigned n;
    n = (32'(i) + 1) % NR;
    return n[IDW-1:0];
  endfunction

  // The priority requester is always excluded from the round-robin scan, so when it is
  // blocked by hipri_last the pointer cannot land on it and hand it back-to-back grants.
  always_comb begin
    win_valid = 1'b0;
    win_hipri = 1'b0;
    win_idx   = '0;
    rr_idx    = 0;
    rr_idx_l  = '0;
    rr_req    = req;
    if (HIPRI_EN) begin
      rr_req[HIPRI_SEL] = 1'b0;
    end
    if (HIPRI_EN && req[HIPRI_SEL] && !(hipri_last_q && (|rr_req))) begin
      win_valid = 1'b1;
      win_hipri = 1'b1;
      win_idx   = IDW'(HIPRI_SEL);
    end else begin
      for (int unsigned k = 0; k < NR; k++) begin
        rr_idx   = (32'(ptr_q) + k) % NR;
        rr_idx_l = rr_idx[IDW-1:0];
        if (!win_valid && rr_req[rr_idx_l]) begin
          win_valid = 1'b1;
          win_idx   = rr_idx_l;
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    gnt_id_d     = gnt_id_q;
    busy_d       = busy_q;
    preempt_d    = 1'b0;
    beat_cnt_d   = beat_cnt_q;
    ptr_d        = ptr_q;
    hipri_last_d = hipri_last_q;

    cur_req  = req[gnt_id_q];
    cur_last = last[gnt_id_q];
    rel_a    = ack_i && cur_last;
    rel_b    = ack_i && !cur_last && (beat_cnt_q == CW'(MAX_BEATS - 1));
    rel_c    = !cur_req;

    case (state_q)
      S_IDLE, S_GAP: begin
        beat_cnt_d = '0;
        if (win_valid) begin
          state_d          = S_GRANT;
          gnt_d            = '0;
          gnt_d[win_idx]   = 1'b1;
          gnt_id_d         = win_idx;
          busy_d           = 1'b1;
          hipri_last_d     = win_hipri;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        if (ack_i && (beat_cnt_q != CW'(MAX_BEATS))) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
        if (rel_a || rel_b || rel_c) begin
          state_d   = S_GAP;
          gnt_d     = '0;
          busy_d    = 1'b0;
          ptr_d     = wrap_inc(gnt_id_q);
          // A cap hit only counts as a preemption if the requester still wants the port.
          preempt_d = rel_b && cur_req;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= S_IDLE;
      gnt_q        <= '0;
      gnt_id_q     <= '0;
      busy_q       <= 1'b0;
      preempt_q    <= 1'b0;
      beat_cnt_q   <= '0;
      ptr_q        <= '0;
      hipri_last_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      gnt_id_q     <= gnt_id_d;
      busy_q       <= busy_d;
      preempt_q    <= preempt_d;
      beat_cnt_q   <= beat_cnt_d;
      ptr_q        <= ptr_d;
      hipri_last_q <= hipri_last_d;
    end
  end

  assign gnt      = gnt_q;
  assign gnt_id   = gnt_id_q;
  assign busy     = busy_q;
  assign preempt  = preempt_q;
  assign beat_cnt = beat_cnt_q;

endmodule
